// File: rtl/mem_stage_sram_controller.sv
// Memory-stage responder that turns each 32-bit load or store from the EXE/MEM
// register into two 16-bit accesses to external SRAM, holding ready low until
// the word has been read or written.
module mem_stage_sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          ACCESS_CYCLES = 2,
    parameter int          SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               memReadEn,
    input  logic               memWriteEn,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in
);

    // Phase counter only needs to reach ACCESS_CYCLES-1; keep at least one bit.
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      phaseCnt;
    logic               isRead;
    logic [SRAM_AW-2:0] wordReg;
    logic [15:0]        wdHi;
    logic [15:0]        loStage;

    logic [31:0]        offset;
    logic [SRAM_AW-2:0] reqWord;
    logic               request;
    logic               lastCycle;
    logic               unusedOffsetBits;

    // Word index relative to the SRAM window; wrap-around subtraction is intended.
    assign offset    = address - BASE_ADDR;
    assign reqWord   = offset[SRAM_AW:2];
    assign request   = memReadEn | memWriteEn;
    assign lastCycle = (phaseCnt == LAST_CNT);

    // Byte offset and bits beyond the SRAM window do not select anything.
    assign unusedOffsetBits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    // Stall the pipeline unless idle with nothing pending or finishing this cycle.
    assign ready = ((state == IDLE) && !request) || (state == DONE);

    // Access sequencer: IDLE -> LO half -> HI half -> DONE, all SRAM pins registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            readData    <= '0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            phaseCnt    <= '0;
            isRead      <= 1'b0;
            wordReg     <= '0;
            wdHi        <= '0;
            loStage     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        // Read wins when both enables are asserted.
                        isRead      <= memReadEn;
                        wordReg     <= reqWord;
                        wdHi        <= writeData[31:16];
                        sram_addr   <= {reqWord, 1'b0};
                        sram_dq_out <= writeData[15:0];
                        sram_we_n   <= memReadEn;
                        sram_dq_oe  <= ~memReadEn;
                        phaseCnt    <= '0;
                        state       <= LO;
                    end
                end
                LO: begin
                    if (lastCycle) begin
                        loStage     <= sram_dq_in;
                        sram_addr   <= {wordReg, 1'b1};
                        sram_dq_out <= wdHi;
                        phaseCnt    <= '0;
                        state       <= HI;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                HI: begin
                    if (lastCycle) begin
                        if (isRead) begin
                            readData <= {sram_dq_in, loStage};
                        end
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        phaseCnt   <= '0;
                        state      <= DONE;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
